ee354_move_cmd_gen: RTL and testbench

- Producer side of the move interface consumed by the 2048 game FSM (up/down/left/right inputs, q_Wait/q_Win/q_Lose outputs).
- Takes four raw, bouncing, asynchronous push-buttons. Synchronizes and debounces them, then picks one direction by fixed priority.
- Issues exactly one single-cycle, one-hot move pulse per physical press, and only while the game FSM is waiting and the game is not over.
- Sits between the board-level button pins and ee354_2048.

---
 rtl/ee354_2048_pkg.sv | 46 ++++
 rtl/ee354_move_cmd_gen_if.sv | 36 +++
 rtl/ee354_btn_sync.sv | 22 ++
 rtl/ee354_move_cmd_gen.sv | 120 ++++++++++++
 tb/tb_ee354_move_cmd_gen.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ee354_2048_pkg.sv
// Shared types for the 2048 move path: direction codes, move-generator states,
// and the {right, left, down, up} move-vector bit order also used by ee354_2048.
package ee354_2048_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        DEBOUNCE = 5'b00010,
        PENDING  = 5'b00100,
        ISSUE    = 5'b01000,
        RELEASE  = 5'b10000
    } state_e;

    localparam int MV_UP    = 0;
    localparam int MV_DOWN  = 1;
    localparam int MV_LEFT  = 2;
    localparam int MV_RIGHT = 3;

    typedef logic [3:0] move_t;

    // Fixed priority: UP > DOWN > LEFT > RIGHT.
    function automatic dir_e pick_dir(move_t b);
        dir_e d;
        priority case (1'b1)
            b[MV_UP]:   d = DIR_UP;
            b[MV_DOWN]: d = DIR_DOWN;
            b[MV_LEFT]: d = DIR_LEFT;
            default:    d = DIR_RIGHT;
        endcase
        return d;
    endfunction

    function automatic move_t dir_to_move(dir_e d);
        move_t m;
        m = '0;
        m[d] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ee354_move_cmd_gen_if.sv
// Move-command bus between the button front end and the 2048 game FSM.
// master: drives one-hot move pulses, busy, move_count; slave: drives ready, game_over.
interface ee354_move_cmd_gen_if;

    logic        ready;
    logic        game_over;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        busy;
    logic [15:0] move_count;

    modport master (
        input  ready,
        input  game_over,
        output up,
        output down,
        output left,
        output right,
        output busy,
        output move_count
    );

    modport slave (
        output ready,
        output game_over,
        input  up,
        input  down,
        input  left,
        input  right,
        input  busy,
        input  move_count
    );

endinterface

// File: rtl/ee354_btn_sync.sv
// Single-bit two-flop synchronizer for an asynchronous button level.
// Ports: Clk, Reset (sync, active-low), d (raw async in), q (synced out).
module ee354_btn_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ee354_move_cmd_gen.sv
// Debounced button front end: one one-hot move pulse per press, only while ready.
// Ports: Clk, Reset (sync, active-low), btn_* raw buttons, mv (move bus master).
module ee354_move_cmd_gen
    import ee354_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    ee354_move_cmd_gen_if.master mv
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    move_t raw;
    move_t syn;

    assign raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        ee354_btn_sync u_sync (
            .Clk   (Clk),
            .Reset (Reset),
            .d     (raw[i]),
            .q     (syn[i])
        );
    end

    state_e           state;
    dir_e             dir;
    logic [CNT_W-1:0] cnt;
    move_t            move_q;
    logic             busy_q;
    logic [15:0]      move_cnt;
    logic             take;

    // game_over beats ready when both are seen in PENDING.
    assign take = (state == PENDING) && !mv.game_over && mv.ready;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            dir      <= DIR_UP;
            cnt      <= '0;
            move_q   <= '0;
            busy_q   <= 1'b0;
            move_cnt <= '0;
        end else begin
            // Pulse is raised on the edge leaving PENDING, so it is
            // visible exactly for the ISSUE cycle.
            move_q   <= take ? dir_to_move(dir) : '0;
            move_cnt <= move_cnt + 16'(take);
            unique case (state)
                IDLE: begin
                    if (|syn) begin
                        dir    <= pick_dir(syn);
                        cnt    <= '0;
                        state  <= DEBOUNCE;
                        busy_q <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!syn[dir]) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= PENDING;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (mv.game_over) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (mv.ready) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Every button must be low for the full window;
                    // any press restarts it, so holding never repeats.
                    if (|syn) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt    <= '0;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mv.up         = move_q[MV_UP];
    assign mv.down       = move_q[MV_DOWN];
    assign mv.left       = move_q[MV_LEFT];
    assign mv.right      = move_q[MV_RIGHT];
    assign mv.busy       = busy_q;
    assign mv.move_count = move_cnt;

endmodule

// File: tb/tb_ee354_move_cmd_gen.sv
// Randomized self-checking bench for ee354_move_cmd_gen (DEBOUNCE 4 and 1).
// Ports: none; drives two DUT instances from shared buttons/ready/game_over.
module tb_ee354_move_cmd_gen;

    localparam int P_WAIT  = 0;
    localparam int P_QUAL  = 1;
    localparam int P_GRANT = 2;
    localparam int P_FIRE  = 3;
    localparam int P_REL   = 4;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic ready = 1'b0;
    logic game_over = 1'b0;

    always #5 Clk = ~Clk;

    ee354_move_cmd_gen_if i0 ();
    ee354_move_cmd_gen_if i1 ();

    assign i0.ready = ready;
    assign i1.ready = ready;
    assign i0.game_over = game_over;
    assign i1.game_over = game_over;

    ee354_move_cmd_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .Clk(Clk), .Reset(Reset),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .mv(i0.master)
    );

    ee354_move_cmd_gen #(.DEBOUNCE_CYCLES(1), .CNT_W(20)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .mv(i1.master)
    );

    wire [3:0]  mv0 = {i0.right, i0.left, i0.down, i0.up};
    wire [3:0]  mv1 = {i1.right, i1.left, i1.down, i1.up};
    wire [41:0] got = {mv0, i0.busy, i0.move_count,
                       mv1, i1.busy, i1.move_count};

    // Reference model: behaviour of a press as seen by the game FSM.
    int          dc [2] = '{4, 1};
    logic [3:0]  m_s1 [2];
    logic [3:0]  m_s2 [2];
    int          m_ph [2];
    int          m_run [2];
    int          m_dir [2];
    logic [3:0]  e_mv [2];
    logic        e_busy [2];
    logic [15:0] e_cnt [2];
    logic [41:0] expv;

    int seen [2][4];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic model_step(input int m);
        logic [3:0] cur;
        if (!Reset) begin
            m_s1[m] = '0; m_s2[m] = '0;
            m_ph[m] = P_WAIT; m_run[m] = 0; m_dir[m] = 0;
            e_mv[m] = '0; e_busy[m] = 1'b0; e_cnt[m] = '0;
        end else begin
            cur = m_s2[m];
            m_s2[m] = m_s1[m];
            m_s1[m] = {btn_right, btn_left, btn_down, btn_up};
            e_mv[m] = '0;
            case (m_ph[m])
                P_WAIT: if (cur != 0) begin
                    m_dir[m] = cur[0] ? 0 : cur[1] ? 1 : cur[2] ? 2 : 3;
                    m_run[m] = 0;
                    m_ph[m] = P_QUAL;
                end
                P_QUAL: if (!cur[m_dir[m]]) m_ph[m] = P_WAIT;
                    else begin
                        m_run[m]++;
                        if (m_run[m] == dc[m]) m_ph[m] = P_GRANT;
                    end
                P_GRANT: if (game_over) begin
                        m_ph[m] = P_REL; m_run[m] = 0;
                    end else if (ready) begin
                        e_mv[m][m_dir[m]] = 1'b1;
                        e_cnt[m] = e_cnt[m] + 16'd1;
                        m_ph[m] = P_FIRE;
                    end
                P_FIRE: begin m_ph[m] = P_REL; m_run[m] = 0; end
                default: if (cur != 0) m_run[m] = 0;
                    else begin
                        m_run[m]++;
                        if (m_run[m] == dc[m]) m_ph[m] = P_WAIT;
                    end
            endcase
            e_busy[m] = (m_ph[m] != P_WAIT);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        expv = {e_mv[0], e_busy[0], e_cnt[0], e_mv[1], e_busy[1], e_cnt[1]};
        @(negedge Clk);
        cyc++;
        for (int d = 0; d < 4; d++) begin
            seen[0][d] += int'(mv0[d]);
            seen[1][d] += int'(mv1[d]);
        end
    endtask

    task automatic clr_seen();
        for (int m = 0; m < 2; m++)
            for (int d = 0; d < 4; d++) seen[m][d] = 0;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        set_btn(4'h0);
        repeat (3) begin
            tick();
            n_vec++;
            if (got !== 42'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc, got);
            end
        end
        Reset = 1'b1;
        repeat (3) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL reset_exit cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
    endtask

    task automatic test_single_press();
        int first [2];
        first = '{-1, -1};
        clr_seen();
        ready = 1'b1;
        btn_up = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL press cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
            if (first[0] < 0 && mv0[0]) first[0] = k;
            if (first[1] < 0 && mv1[0]) first[1] = k;
        end
        btn_up = 1'b0;
        repeat (10) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL press_rel cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        n_vec++;
        if (first[0] !== 8 || first[1] !== 5) begin
            n_err++;
            $display("FAIL press_latency got=%0d/%0d exp=8/5", first[0], first[1]);
        end
        n_vec++;
        if (seen[0][0] !== 1 || i0.move_count !== 16'd1) begin
            n_err++;
            $display("FAIL press_once got=%0d cnt=%0d exp=1 cnt=1",
                     seen[0][0], i0.move_count);
        end
    endtask

    task automatic test_bounce();
        int tot;
        clr_seen();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            btn_left = (i % 4) >= 2;
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        tot = seen[0][0] + seen[0][1] + seen[0][2] + seen[0][3];
        n_vec++;
        if (tot !== 0) begin
            n_err++;
            $display("FAIL bounce_quiet got=%0d pulses exp=0", tot);
        end
        btn_left = 1'b1;
        repeat (10) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL bounce_hold cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        btn_left = 1'b0;
        repeat (10) tick();
        tot = seen[0][0] + seen[0][1] + seen[0][2] + seen[0][3];
        n_vec++;
        if (seen[0][2] !== 1 || tot !== 1) begin
            n_err++;
            $display("FAIL bounce_one got=%0d left/%0d all exp=1/1", seen[0][2], tot);
        end
    endtask

    task automatic test_ready_wait();
        int tot;
        clr_seen();
        ready = 1'b0;
        btn_down = 1'b1;
        repeat (50) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL wait cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        tot = seen[0][1] + seen[1][1];
        n_vec++;
        if (tot !== 0 || i0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL wait_hold got=%0d busy=%b exp=0 busy=1", tot, i0.busy);
        end
        ready = 1'b1;
        tick();
        n_vec++;
        if (mv0 !== 4'b0010 || mv1 !== 4'b0010) begin
            n_err++;
            $display("FAIL wait_grant got=%b/%b exp=0010/0010", mv0, mv1);
        end
        repeat (100) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL no_repeat cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        btn_down = 1'b0;
        repeat (10) tick();
        tot = seen[0][0] + seen[0][1] + seen[0][2] + seen[0][3];
        n_vec++;
        if (tot !== 1) begin
            n_err++;
            $display("FAIL no_repeat_cnt got=%0d exp=1", tot);
        end
    endtask

    task automatic test_priority();
        clr_seen();
        Reset = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        ready = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: set_btn(4'b1001);
                2: set_btn(4'b1000);
                default: set_btn(4'b0000);
            endcase
            repeat (15) begin
                tick();
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL prio cyc=%0d got=%h exp=%h", cyc, got, expv);
                end
            end
        end
        n_vec++;
        if (seen[0][0] !== 1 || seen[0][3] !== 1 || seen[0][1] + seen[0][2] !== 0) begin
            n_err++;
            $display("FAIL prio_dir got=up%0d right%0d exp=1/1", seen[0][0], seen[0][3]);
        end
        n_vec++;
        if (i0.move_count !== 16'd2 || i1.move_count !== 16'd2) begin
            n_err++;
            $display("FAIL prio_cnt got=%0d/%0d exp=2/2", i0.move_count, i1.move_count);
        end
    endtask

    task automatic test_game_over();
        int tot;
        clr_seen();
        ready = 1'b1;
        game_over = 1'b1;
        btn_left = 1'b1;
        repeat (20) begin
            tick();
            n_vec++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL gover cyc=%0d got=%h exp=%h", cyc, got, expv);
            end
        end
        btn_left = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (i0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL gover_busy got=%b exp=1", i0.busy);
        end
        repeat (6) tick();
        tot = seen[0][0] + seen[0][1] + seen[0][2] + seen[0][3];
        n_vec++;
        if (i0.busy !== 1'b0 || tot !== 0 || i0.move_count !== 16'd2) begin
            n_err++;
            $display("FAIL gover_end got=busy%b p%0d c%0d exp=busy0 p0 c2",
                     i0.busy, tot, i0.move_count);
        end
        game_over = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        for (int s = 0; s < 2; s++) begin
            ready = (s == 1);
            btn_up = 1'b1;
            k = 0;
            while (m_ph[0] != (s == 0 ? P_GRANT : P_FIRE) && k < 30) begin
                tick();
                k++;
            end
            n_vec++;
            if (k >= 30) begin
                n_err++;
                $display("FAIL rst_mid_timeout scen=%0d got=%0d cycles exp<30", s, k);
            end
            if (s == 1) begin
                n_vec++;
                if (mv0 !== 4'b0001) begin
                    n_err++;
                    $display("FAIL rst_mid_issue got=%b exp=0001", mv0);
                end
            end
            Reset = 1'b0;
            tick();
            n_vec++;
            if (got !== 42'd0) begin
                n_err++;
                $display("FAIL rst_mid scen=%0d got=%h exp=0", s, got);
            end
            Reset = 1'b1;
            btn_up = 1'b0;
            repeat (10) begin
                tick();
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL rst_after cyc=%0d got=%h exp=%h", cyc, got, expv);
                end
            end
        end
    endtask

    task automatic test_wrap();
        set_btn(4'h0);
        ready = 1'b1;
        repeat (10) tick();
        force dut.move_cnt = 16'hFFFF;
        force dut1.move_cnt = 16'hFFFF;
        tick();
        release dut.move_cnt;
        release dut1.move_cnt;
        e_cnt[0] = 16'hFFFF;
        e_cnt[1] = 16'hFFFF;
        expv = {e_mv[0], e_busy[0], e_cnt[0], e_mv[1], e_busy[1], e_cnt[1]};
        tick();
        n_vec++;
        if (i0.move_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_pre got=%h exp=ffff", i0.move_count);
        end
        for (int ph = 0; ph < 2; ph++) begin
            btn_right = (ph == 0);
            repeat (15) begin
                tick();
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, got, expv);
                end
            end
        end
        n_vec++;
        if (i0.move_count !== 16'h0000 || i1.move_count !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_zero got=%h/%h exp=0000/0000",
                     i0.move_count, i1.move_count);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 9) < 4) set_btn(4'h0);
            else set_btn(4'($urandom_range(1, 15)));
            ready = $urandom_range(0, 3) != 0;
            game_over = $urandom_range(0, 9) == 0;
            Reset = $urandom_range(0, 99) != 0;
            hold = Reset ? $urandom_range(1, 10) : 1;
            repeat (hold) begin
                tick();
                n_vec++;
                if (got !== expv) begin
                    n_err++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, expv);
                end
            end
            Reset = 1'b1;
        end
        game_over = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_ready_wait();
        test_priority();
        test_game_over();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
